// File: rtl/water_tank_model.sv
// Plant model of the regulated water tank: integrates the net flow into a
// saturating level at a fixed tick rate and derives the hysteretic sensor bits.
module water_tank_model #(
  parameter int LEVEL_W   = 10,
  parameter int LEVEL_MAX = 1000,
  parameter int TH1       = 250,
  parameter int TH2       = 500,
  parameter int TH3       = 750,
  parameter int HYST      = 4,
  parameter int R1        = 4,
  parameter int R2        = 4,
  parameter int R3        = 4,
  parameter int RD        = 2,
  parameter int TICK_DIV  = 16,
  parameter int DRAIN_W   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fr1,
  input  logic               fr2,
  input  logic               fr3,
  input  logic               dfr,
  input  logic [DRAIN_W-1:0] drain,
  input  logic               load,
  input  logic [LEVEL_W-1:0] load_level,
  output logic [3:1]         s,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               overflow,
  output logic               underflow
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SW    = LEVEL_W + 2;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic signed [SW-1:0] MAX_S  = SW'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(LEVEL_MAX);

  logic [CNT_W-1:0]     cnt;
  logic signed [SW-1:0] inflow;
  logic signed [SW-1:0] raw;
  logic [LEVEL_W-1:0]   next_level;
  logic                 clip_hi;
  logic                 clip_lo;
  logic [LEVEL_W-1:0]   load_clamped;
  logic [3:1]           s_next;

  // Per-bit hysteresis: set at/above threshold, clear below threshold-HYST.
  function automatic logic hyst_bit(input logic cur, input logic [LEVEL_W-1:0] lv,
                                    input int th);
    if (lv >= LEVEL_W'(th))
      return 1'b1;
    else if (lv < LEVEL_W'(th - HYST))
      return 1'b0;
    else
      return cur;
  endfunction

  always_comb begin
    inflow = '0;
    if (fr1) inflow = inflow + SW'(R1);
    if (fr2) inflow = inflow + SW'(R2);
    if (fr3) inflow = inflow + SW'(R3);
    if (dfr) inflow = inflow + SW'(RD);

    raw = $signed({2'b00, level}) + inflow - $signed(SW'(drain));

    next_level = raw[LEVEL_W-1:0];
    clip_hi    = 1'b0;
    clip_lo    = 1'b0;
    if (raw > MAX_S) begin
      next_level = MAX_L;
      clip_hi    = 1'b1;
    end else if (raw[SW-1]) begin
      next_level = '0;
      clip_lo    = 1'b1;
    end

    load_clamped = (load_level > MAX_L) ? MAX_L : load_level;

    s_next[1] = hyst_bit(s[1], level, TH1);
    s_next[2] = hyst_bit(s[2], level, TH2);
    s_next[3] = hyst_bit(s[3], level, TH3);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      level     <= '0;
      tick      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      s         <= 3'b000;
    end else begin
      s    <= s_next;
      tick <= 1'b0;
      // A load discards any update that would have happened on this edge.
      if (load) begin
        cnt       <= '0;
        level     <= load_clamped;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= next_level;
        tick  <= 1'b1;
        if (clip_hi) overflow  <= 1'b1;
        if (clip_lo) underflow <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_water_tank_model.sv
// Scoreboard bench for water_tank_model: expected levels are queued when the
// flow stimulus is applied and popped at each tick.
module tb_water_tank_model;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fr1 = 1'b0, fr2 = 1'b0, fr3 = 1'b0, dfr = 1'b0;
  logic [4:0] drain = '0;
  logic       load = 1'b0;
  logic [9:0] load_level = '0;
  logic [3:1] s;
  logic [9:0] level;
  logic       tick;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int model;

  water_tank_model dut (
    .clk(clk), .reset_n(reset_n),
    .fr1(fr1), .fr2(fr2), .fr3(fr3), .dfr(dfr),
    .drain(drain), .load(load), .load_level(load_level),
    .s(s), .level(level), .tick(tick),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int step_model(input int lv);
    int r;
    r = lv + (fr1 ? 4 : 0) + (fr2 ? 4 : 0) + (fr3 ? 4 : 0) + (dfr ? 2 : 0) - int'(drain);
    if (r > 1000) r = 1000;
    if (r < 0) r = 0;
    return r;
  endfunction

  task automatic wait_tick(input int bound, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (tick === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    load = 1'b1;
    load_level = 10'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    bit seen; int cyc; int e;
    do_load(300);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (level !== 10'd300) begin n_bad++; $display("FAIL reset_preload: level=%0d exp=300", level); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({level, s, tick, overflow, underflow} !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_async: level=%0d s=%b tick=%b ovf=%b unf=%b exp all 0",
               level, s, tick, overflow, underflow);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model = 0;
    exp_q.push_back(step_model(model));
    wait_tick(40, seen, cyc);
    n_cmp++;
    if (!seen || cyc != 16) begin n_bad++; $display("FAIL reset_first_tick: seen=%0b cycles=%0d exp 16", seen, cyc); end
    e = exp_q.pop_front();
    n_cmp++;
    if (level !== 10'(e)) begin n_bad++; $display("FAIL reset_tick_level: level=%0d exp=%0d", level, e); end
  endtask

  task automatic test_fill;
    bit seen; int cyc; int e;
    @(negedge clk);
    reset_n = 1'b0;
    {fr1, fr2, fr3, dfr} = 4'b1111;
    drain = 5'd0;
    @(negedge clk);
    reset_n = 1'b1;
    model = 0;
    for (int k = 1; k <= 18; k++) begin
      model = step_model(model);
      exp_q.push_back(model);
      wait_tick(40, seen, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || cyc != 16 || level !== 10'(e)) begin
        n_bad++;
        $display("FAIL fill_tick%0d: seen=%0b cycles=%0d level=%0d exp level=%0d cycles=16",
                 k, seen, cyc, level, e);
      end
      if (k == 17) begin
        n_cmp++;
        if (level !== 10'd238) begin n_bad++; $display("FAIL fill_17: level=%0d exp=238", level); end
      end
    end
    n_cmp++;
    if (level !== 10'd252 || s[1] !== 1'b0) begin
      n_bad++; $display("FAIL fill_18: level=%0d s1=%b exp 252/0", level, s[1]);
    end
    @(negedge clk);
    n_cmp++;
    if (s !== 3'b001) begin n_bad++; $display("FAIL fill_s1_rise: s=%b exp=001", s); end
  endtask

  task automatic test_hysteresis;
    bit seen; int cyc; int e;
    @(negedge clk);
    {fr1, fr2, fr3, dfr} = 4'b0000;
    drain = 5'd1;
    do_load(500);
    model = 500;
    for (int k = 0; k < 5; k++) begin
      model = step_model(model);
      exp_q.push_back(model);
      wait_tick(40, seen, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || level !== 10'(e) || s[2:1] !== 2'b11) begin
        n_bad++;
        $display("FAIL hyst_tick%0d: seen=%0b level=%0d s=%b exp level=%0d s[2:1]=11",
                 k, seen, level, s, e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (s[2:1] !== 2'b01) begin n_bad++; $display("FAIL hyst_s2_clear: s=%b exp s[2:1]=01", s); end
  endtask

  task automatic test_overflow;
    bit seen; int cyc; int e;
    @(negedge clk);
    {fr1, fr2, fr3, dfr} = 4'b1111;
    drain = 5'd0;
    do_load(995);
    model = 995;
    n_cmp++;
    if (overflow !== 1'b0 || level !== 10'd995) begin
      n_bad++; $display("FAIL ovf_load: level=%0d ovf=%b exp 995/0", level, overflow);
    end
    for (int k = 0; k < 2; k++) begin
      model = step_model(model);
      exp_q.push_back(model);
      wait_tick(40, seen, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || level !== 10'(e) || overflow !== 1'b1 || s !== 3'b111) begin
        n_bad++;
        $display("FAIL ovf_tick%0d: seen=%0b level=%0d ovf=%b s=%b exp level=%0d ovf=1 s=111",
                 k, seen, level, overflow, s, e);
      end
    end
  endtask

  task automatic test_underflow;
    bit seen; int cyc; int e;
    @(negedge clk);
    {fr1, fr2, fr3, dfr} = 4'b0000;
    drain = 5'd31;
    do_load(20);
    model = 20;
    n_cmp++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL unf_load_flags: ovf=%b unf=%b exp 0/0", overflow, underflow);
    end
    model = step_model(model);
    exp_q.push_back(model);
    wait_tick(40, seen, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || level !== 10'(e) || underflow !== 1'b1 || overflow !== 1'b0 || s !== 3'b000) begin
      n_bad++;
      $display("FAIL unf_tick: seen=%0b level=%0d unf=%b ovf=%b s=%b exp level=%0d unf=1 ovf=0 s=000",
               seen, level, underflow, overflow, s, e);
    end
  endtask

  task automatic test_load_collision;
    bit seen; int cyc; int e;
    exp_q.push_back(step_model(model));
    wait_tick(40, seen, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || level !== 10'(e) || underflow !== 1'b1) begin
      n_bad++; $display("FAIL coll_align: seen=%0b level=%0d unf=%b exp level=%0d unf=1", seen, level, underflow, e);
    end
    repeat (15) @(negedge clk);
    load = 1'b1;
    load_level = 10'd1023;
    {fr1, fr2, fr3, dfr} = 4'b1000;
    drain = 5'd4;
    @(negedge clk);
    load = 1'b0;
    n_cmp++;
    if (tick !== 1'b0 || level !== 10'd1000 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL coll_load: tick=%b level=%0d ovf=%b unf=%b exp 0/1000/0/0", tick, level, overflow, underflow);
    end
    model = 1000;
    exp_q.push_back(step_model(model));
    wait_tick(40, seen, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || cyc != 16 || level !== 10'(e) || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL coll_next_tick: seen=%0b cycles=%0d level=%0d ovf=%b unf=%b exp cycles=16 level=%0d flags 0",
               seen, cyc, level, overflow, underflow, e);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({level, s, tick, overflow, underflow} !== 16'd0) begin
      n_bad++; $display("FAIL init_reset: level=%0d s=%b tick=%b exp all 0", level, s, tick);
    end
    reset_n = 1'b1;
    test_reset;
    test_fill;
    test_hysteresis;
    test_overflow;
    test_underflow;
    test_load_collision;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
